// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared crossbar types
package xbar_pkg;

  // AW arbiter holds the W path for one burst after each grant
  typedef enum logic {
    ARB     = 1'b0,
    W_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin picker
// Returns the first asserted request at or after ptr, wrapping modulo N.
module rr_select #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] winner
);

  int idx;

  // Scan farthest-first so the closest request to ptr is the last one written
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        any    = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/addr_forward_arbiter.sv
// rtl/addr_forward_arbiter.sv - per-slave address channel forward arbiter
// Round-robin grant of master address heads into one slave, with W-burst lock and outstanding cap.
module addr_forward_arbiter
  import xbar_pkg::*;
#(
  parameter int masters           = 2,
  parameter int slaves            = 2,
  parameter int i_am_slave_number = 0,
  parameter int WRITE_MODE        = 0,
  parameter int MAX_OUTSTANDING   = 8
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic                                 master_fifo_empty [0:masters-1],
  input  logic [$clog2(slaves)-1:0]            master_dest_slave [0:masters-1],
  input  logic                                 slave_fifo_full,
  input  logic                                 last_beat_accepted,
  input  logic                                 resp_done,
  output logic [$clog2(masters)-1:0]           grant_master_number,
  output logic                                 push_to_fifo,
  output logic                                 w_active,
  output logic [$clog2(masters)-1:0]           w_master_number,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int MST_W = $clog2(masters);
  localparam int SLV_W = $clog2(slaves);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t       state;
  logic [MST_W-1:0] rr_ptr;
  logic [MST_W-1:0] last_grant;
  logic [MST_W-1:0] w_master;
  logic [OUT_W-1:0] out_cnt;

  logic [masters-1:0] req;
  logic               req_any;
  logic [MST_W-1:0]   winner;
  logic [MST_W-1:0]   next_ptr;
  logic               push;
  logic               resp_eff;

  always_comb begin
    req = '0;
    for (int i = 0; i < masters; i++) begin
      req[i] = ~master_fifo_empty[i] & (master_dest_slave[i] == SLV_W'(i_am_slave_number));
    end
  end

  rr_select #(
    .N (masters),
    .W (MST_W)
  ) u_rr_select (
    .req    (req),
    .ptr    (rr_ptr),
    .any    (req_any),
    .winner (winner)
  );

  // Reset gates the grant so nothing is popped while state is being cleared
  assign push = req_any & ~slave_fifo_full & (state == ARB)
              & (out_cnt < OUT_W'(MAX_OUTSTANDING)) & ~ARESET;

  // A completion with nothing outstanding is spurious and dropped
  assign resp_eff = resp_done & (out_cnt != '0);
  assign next_ptr = (winner == MST_W'(masters - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= ARB;
      rr_ptr     <= '0;
      last_grant <= '0;
      w_master   <= '0;
      out_cnt    <= '0;
    end else begin
      if (push) begin
        rr_ptr     <= next_ptr;
        last_grant <= winner;
      end

      case ({push, resp_eff})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      if (WRITE_MODE != 0) begin
        case (state)
          ARB: begin
            if (push) begin
              state    <= W_BURST;
              w_master <= winner;
            end
          end
          W_BURST: begin
            if (last_beat_accepted) state <= ARB;
          end
          default: state <= ARB;
        endcase
      end
    end
  end

  assign push_to_fifo        = push;
  assign grant_master_number = push ? winner : last_grant;
  assign w_active            = (state == W_BURST);
  assign w_master_number     = w_master;
  assign outstanding         = out_cnt;

endmodule

// File: tb/tb_addr_forward_arbiter.sv
// tb/tb_addr_forward_arbiter.sv - bench for addr_forward_arbiter
module tb_addr_forward_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_failed = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A: read mode, 2 masters, cap 2
  logic       a_rst;
  logic       a_empty [0:1];
  logic [0:0] a_dest  [0:1];
  logic       a_full, a_last, a_resp;
  logic [0:0] a_grant, a_wm;
  logic       a_push, a_wact;
  logic [1:0] a_out;

  addr_forward_arbiter #(.masters(2), .slaves(2), .i_am_slave_number(0),
                         .WRITE_MODE(0), .MAX_OUTSTANDING(2)) u_a (
    .ACLK(clk), .ARESET(a_rst), .master_fifo_empty(a_empty), .master_dest_slave(a_dest),
    .slave_fifo_full(a_full), .last_beat_accepted(a_last), .resp_done(a_resp),
    .grant_master_number(a_grant), .push_to_fifo(a_push), .w_active(a_wact),
    .w_master_number(a_wm), .outstanding(a_out));

  // B: write mode, 2 masters, cap 8
  logic       b_rst;
  logic       b_empty [0:1];
  logic [0:0] b_dest  [0:1];
  logic       b_full, b_last, b_resp;
  logic [0:0] b_grant, b_wm;
  logic       b_push, b_wact;
  logic [3:0] b_out;

  addr_forward_arbiter #(.masters(2), .slaves(2), .i_am_slave_number(0),
                         .WRITE_MODE(1), .MAX_OUTSTANDING(8)) u_b (
    .ACLK(clk), .ARESET(b_rst), .master_fifo_empty(b_empty), .master_dest_slave(b_dest),
    .slave_fifo_full(b_full), .last_beat_accepted(b_last), .resp_done(b_resp),
    .grant_master_number(b_grant), .push_to_fifo(b_push), .w_active(b_wact),
    .w_master_number(b_wm), .outstanding(b_out));

  // C: write mode, 3 masters (non power-of-two wrap), slave 2, cap 3
  logic       c_rst;
  logic       c_empty [0:2];
  logic [1:0] c_dest  [0:2];
  logic       c_full, c_last, c_resp;
  logic [1:0] c_grant, c_wm;
  logic       c_push, c_wact;
  logic [1:0] c_out;

  addr_forward_arbiter #(.masters(3), .slaves(3), .i_am_slave_number(2),
                         .WRITE_MODE(1), .MAX_OUTSTANDING(3)) u_c (
    .ACLK(clk), .ARESET(c_rst), .master_fifo_empty(c_empty), .master_dest_slave(c_dest),
    .slave_fifo_full(c_full), .last_beat_accepted(c_last), .resp_done(c_resp),
    .grant_master_number(c_grant), .push_to_fifo(c_push), .w_active(c_wact),
    .w_master_number(c_wm), .outstanding(c_out));

  typedef struct {
    logic e0, e1, d0, d1, full, resp, last;
    int   exp_push, exp_grant, exp_out;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic e0, e1, d0, d1, full, resp, last,
                     input int p, g, o);
    vec_t v;
    v.e0 = e0; v.e1 = e1; v.d0 = d0; v.d1 = d1;
    v.full = full; v.resp = resp; v.last = last;
    v.exp_push = p; v.exp_grant = g; v.exp_out = o;
    vecs.push_back(v);
  endtask

  task automatic b_drive(input logic e0, e1, last, rst);
    b_empty[0] = e0; b_empty[1] = e1; b_last = last; b_rst = rst;
  endtask

  // Reference model state for C
  int m_ptr, m_lg, m_cnt, m_wm, m_win;
  bit m_burst, m_push;
  bit m_req [0:2];

  initial begin
    a_rst = 1; b_rst = 1; c_rst = 1;
    a_full = 0; a_last = 0; a_resp = 0;
    b_full = 0; b_last = 0; b_resp = 0;
    c_full = 0; c_last = 0; c_resp = 0;
    for (int i = 0; i < 2; i++) begin
      a_empty[i] = 1; a_dest[i] = 0; b_empty[i] = 1; b_dest[i] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      c_empty[i] = 1; c_dest[i] = 0;
    end
    tick();
    tick();

    // ---- A: reset cycle must not grant even with requests present ----
    a_empty[0] = 0; a_empty[1] = 0;
    #3 chk("a_push_in_reset", a_push, 0);
    tick();
    a_rst = 0; a_empty[0] = 1; a_empty[1] = 1;
    #3;
    chk("a_reset_push", a_push, 0);
    chk("a_reset_grant", a_grant, 0);
    chk("a_reset_out", a_out, 0);
    chk("a_reset_wact", a_wact, 0);
    chk("a_reset_wm", a_wm, 0);
    tick();

    //   e0 e1 d0 d1 fu rs la | push grant out_after
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 2);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);

    foreach (vecs[n]) begin
      a_empty[0] = vecs[n].e0; a_empty[1] = vecs[n].e1;
      a_dest[0]  = vecs[n].d0; a_dest[1]  = vecs[n].d1;
      a_full = vecs[n].full; a_resp = vecs[n].resp; a_last = vecs[n].last;
      #3;
      chk($sformatf("a_push[%0d]", n), a_push, vecs[n].exp_push);
      chk($sformatf("a_grant[%0d]", n), a_grant, vecs[n].exp_grant);
      chk($sformatf("a_wact[%0d]", n), a_wact, 0);
      tick();
      chk($sformatf("a_out[%0d]", n), a_out, vecs[n].exp_out);
    end
    a_rst = 1;

    // ---- B: write lock and mid-burst reset ----
    b_drive(1, 1, 1, 0);
    #3;
    chk("b_idle_push", b_push, 0);
    chk("b_idle_grant", b_grant, 0);
    chk("b_idle_wact", b_wact, 0);
    tick();
    b_drive(1, 0, 0, 0);
    #3;
    chk("b_last_in_arb_ignored", b_wact, 0);
    chk("b_grant_m1_push", b_push, 1);
    chk("b_grant_m1", b_grant, 1);
    tick();
    for (int beat = 0; beat < 4; beat++) begin
      b_drive(0, 0, (beat == 3), 0);
      #3;
      chk($sformatf("b_burst_push[%0d]", beat), b_push, 0);
      chk($sformatf("b_burst_wact[%0d]", beat), b_wact, 1);
      chk($sformatf("b_burst_wm[%0d]", beat), b_wm, 1);
      chk($sformatf("b_burst_grant_hold[%0d]", beat), b_grant, 1);
      tick();
    end
    b_drive(0, 0, 0, 0);
    #3;
    chk("b_after_burst_wact", b_wact, 0);
    chk("b_after_burst_push", b_push, 1);
    chk("b_after_burst_grant", b_grant, 0);
    chk("b_out1", b_out, 1);
    tick();
    b_drive(0, 0, 1, 0);
    #3;
    chk("b_burst2_push", b_push, 0);
    chk("b_burst2_wm", b_wm, 0);
    chk("b_out2", b_out, 2);
    tick();
    b_drive(0, 1, 0, 0);
    #3;
    chk("b_third_push", b_push, 1);
    chk("b_third_grant", b_grant, 0);
    tick();
    b_drive(0, 0, 0, 1);
    #3;
    chk("b_reset_cycle_push", b_push, 0);
    chk("b_pre_reset_wact", b_wact, 1);
    chk("b_pre_reset_out", b_out, 3);
    tick();
    b_drive(0, 0, 0, 0);
    #3;
    chk("b_post_reset_wact", b_wact, 0);
    chk("b_post_reset_out", b_out, 0);
    chk("b_post_reset_wm", b_wm, 0);
    chk("b_post_reset_push", b_push, 1);
    chk("b_post_reset_ptr0", b_grant, 0);
    tick();
    b_drive(1, 1, 0, 1);

    // ---- C: random stimulus against behavioural model ----
    m_ptr = 0; m_lg = 0; m_cnt = 0; m_wm = 0; m_burst = 0;
    c_rst = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      c_rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 3; i++) begin
        c_empty[i] = ($urandom_range(0, 3) == 0);
        c_dest[i]  = $urandom_range(0, 1) ? 2'd2 : 2'($urandom_range(0, 3));
      end
      c_full = ($urandom_range(0, 4) == 0);
      c_last = ($urandom_range(0, 2) == 0);
      c_resp = ($urandom_range(0, 2) == 0);

      for (int i = 0; i < 3; i++) m_req[i] = !c_empty[i] && (c_dest[i] == 2);
      m_win = -1;
      for (int k = 0; k < 3; k++) begin
        if (m_win < 0 && m_req[(m_ptr + k) % 3]) m_win = (m_ptr + k) % 3;
      end
      m_push = (m_win >= 0) && !c_full && !m_burst && (m_cnt < 3) && !c_rst;

      #3;
      chk("c_push", c_push, m_push);
      chk("c_grant", c_grant, m_push ? m_win : m_lg);
      chk("c_wact", c_wact, m_burst);
      chk("c_out", c_out, m_cnt);
      if (m_burst) chk("c_wm", c_wm, m_wm);

      if (c_rst) begin
        m_ptr = 0; m_lg = 0; m_cnt = 0; m_wm = 0; m_burst = 0;
      end else begin
        if (c_resp && m_cnt > 0 && !m_push) m_cnt--;
        else if (m_push && !(c_resp && m_cnt > 0)) m_cnt++;
        if (m_push) begin
          m_ptr = (m_win + 1) % 3;
          m_lg = m_win;
          m_wm = m_win;
          m_burst = 1;
        end else if (m_burst && c_last) begin
          m_burst = 0;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
